// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
//   start      : request pulse, accepted only when the block is idle
//   A, B, bin  : minuend, subtrahend, borrow-in (captured on accept)
//   D, bout    : registered difference and final borrow-out
//   busy, done : busy while bits are processed, done pulses on new result
interface serial_subtractor_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       bin;
  logic [7:0] D;
  logic       bout;
  logic       busy;
  logic       done;

  modport master (output start, A, B, bin, input D, bout, busy, done);
  modport slave  (input start, A, B, bin, output D, bout, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor: D = A - B - bin (mod 256), LSB first,
// one bit per clock.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : serial_subtractor_if.slave (start/A/B/bin in, D/bout/busy/done out)
// Timing: start accepted at edge N -> RUN for edges N+1..N+8, done high
// after edge N+8, back in IDLE at edge N+9.
module serial_subtractor (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] a_sr, b_sr, res;
  logic       c;
  logic [2:0] cnt;
  logic [7:0] diff;
  logic       borrow;
  logic       dbit, bnext;

  // full-subtractor cell on the current LSBs
  assign dbit  = a_sr[0] ^ b_sr[0] ^ c;
  assign bnext = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)  state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sr <= bus.A;
          b_sr <= bus.B;
          c    <= bus.bin;
          cnt  <= '0;
        end
        RUN: begin
          a_sr <= {1'b0, a_sr[7:1]};
          b_sr <= {1'b0, b_sr[7:1]};
          res  <= {dbit, res[7:1]};
          c    <= bnext;
          cnt  <= cnt + 3'd1;
          // last bit: publish the result including the bit formed this cycle
          if (cnt == 3'd7) begin
            diff   <= {dbit, res[7:1]};
            borrow <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D    = diff;
  assign bus.bout = borrow;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  serial_subtractor_if bus();

  serial_subtractor dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passed++;
  endtask

  // One operation; samples on falling edges. k=0 is the cycle after the
  // accepting edge, so done is expected at k=8.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        output logic [7:0] d, output logic bo,
                        output int lat, output int busyc, output int donec,
                        output bit hold_ok);
    logic [7:0] prev_d;
    logic       prev_bo;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.bin = bi; bus.start = 1'b1;
    prev_d = bus.D; prev_bo = bus.bout;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.bin = ~bi;
    lat = -1; busyc = 0; donec = 0; hold_ok = 1'b1; d = '0; bo = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) begin
        busyc++;
        if (bus.D !== prev_d || bus.bout !== prev_bo) hold_ok = 1'b0;
      end
      if (bus.done) begin
        donec++;
        if (lat < 0) begin lat = k; d = bus.D; bo = bus.bout; end
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       bo;
    int         lat, busyc, donec;
    bit         hold_ok;
    logic [8:0] ref9;
    int         didx [$];
    bit         stable;

    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.bin = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_D", bus.D, 8'h00);
    check("rst_bout", bus.bout, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    // directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, busyc, donec, hold_ok);
      check($sformatf("vec%0d_D", i), d, vecs[i].d);
      check($sformatf("vec%0d_bout", i), bo, vecs[i].bout);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), busyc, 8);
      check($sformatf("vec%0d_done_count", i), donec, 1);
      check($sformatf("vec%0d_hold", i), hold_ok, 1'b1);
    end

    // start during RUN is ignored
    @(negedge clk);
    bus.A = 8'h10; bus.B = 8'h01; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    donec = 0; d = '0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.done) begin donec++; d = bus.D; end
      if (k == 2) begin bus.A = 8'h00; bus.B = 8'hFF; bus.start = 1'b1; end
      if (k == 3) bus.start = 1'b0;
    end
    check("ignore_done_count", donec, 1);
    check("ignore_D_at_done", d, 8'h0F);
    check("ignore_D_final", bus.D, 8'h0F);

    // reset in the middle of RUN
    @(negedge clk);
    bus.A = 8'h77; bus.B = 8'h11; bus.bin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_D", bus.D, 8'h00);
    check("abort_bout", bus.bout, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    donec = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) donec++;
    end
    check("abort_no_done", donec, 0);
    check("abort_D_stays", bus.D, 8'h00);
    run_op(8'h77, 8'h11, 1'b0, d, bo, lat, busyc, donec, hold_ok);
    check("post_rst_D", d, 8'h66);
    check("post_rst_bout", bo, 1'b0);
    check("post_rst_latency", lat, 8);

    // start held high: one result every 10 cycles
    @(negedge clk);
    bus.A = 8'h9C; bus.B = 8'h3B; bus.bin = 1'b1; bus.start = 1'b1;
    stable = 1'b1; busyc = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.done) didx.push_back(k);
      if (bus.busy) busyc++;
      if (k >= 8 && (bus.D !== 8'h60 || bus.bout !== 1'b0)) stable = 1'b0;
      if (k == 29) bus.start = 1'b0;
    end
    check("b2b_done_count", didx.size(), 3);
    if (didx.size() == 3) begin
      check("b2b_first_done", didx[0], 8);
      check("b2b_spacing1", didx[1] - didx[0], 10);
      check("b2b_spacing2", didx[2] - didx[1], 10);
    end
    check("b2b_D_stable", stable, 1'b1);
    check("b2b_busy_cycles", busyc, 24);

    // strided sweep against a 9-bit arithmetic model
    for (int a = 0; a < 256; a += 7)
      for (int b = 0; b < 256; b += 11)
        for (int ci = 0; ci < 2; ci++) begin
          run_op(a[7:0], b[7:0], ci[0], d, bo, lat, busyc, donec, hold_ok);
          ref9 = {1'b0, a[7:0]} - {1'b0, b[7:0]} - {8'd0, ci[0]};
          check($sformatf("sweep_%0h_%0h_%0d", a, b, ci), {23'd0, bo, d}, {23'd0, ref9});
        end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
